// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine.
// States, default data width and {cpol,cpha} mode codes.
`timescale 1ns/1ps
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Edge n (1-based) samples miso when it is odd for cpha=0
    // and even for cpha=1; edge_idx is the 0-based count.
    function automatic logic is_sample_edge(input logic cpha,
                                            input logic edge_idx_lsb);
        return cpha ? edge_idx_lsb : ~edge_idx_lsb;
    endfunction

endpackage

// File: rtl/spi_half_period_tick.sv
// SCK half-period timer: 8-bit down counter with load/enable.
// Ticks for one clock at zero and reloads from the divider.
`timescale 1ns/1ps
module spi_half_period_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == 8'd0);

    // Count div..0 so one half-period spans div+1 clocks (0xFF -> 256).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= div;
        end else if (en) begin
            if (cnt == 8'd0) begin
                cnt <= div;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Bit-level SPI master: one byte per req/ready handshake,
// all four CPOL/CPHA modes, MSB first, programmable SCK rate.
`timescale 1ns/1ps
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        clk_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              transfer_req,
    output logic              transfer_ready,
    output logic              transfer_done,
    input  logic [DATA_W-1:0] to_agent,
    output logic [DATA_W-1:0] from_agent,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    localparam int EW = $clog2(2 * DATA_W + 1);

    state_t            state;
    state_t            nxt;
    logic              accept;
    logic              tick_en;
    logic              tick;
    logic [7:0]        div_q;
    logic [7:0]        div_sel;
    logic              cpol_q;
    logic              cpha_q;
    logic [EW-1:0]     ecnt;
    logic [DATA_W-1:0] sr;
    logic              last_edge;
    logic              sample_edge;

    assign div_sel     = accept ? clk_div : div_q;
    assign last_edge   = (ecnt == EW'(2 * DATA_W - 1));
    assign sample_edge = is_sample_edge(cpha_q, ecnt[0]);

    spi_half_period_tick u_tick (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (tick_en),
        .div   (div_sel),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        nxt            = state;
        accept         = 1'b0;
        tick_en        = 1'b0;
        transfer_ready = 1'b0;
        unique case (state)
            IDLE: begin
                transfer_ready = 1'b1;
                if (transfer_req) begin
                    accept = 1'b1;
                    nxt    = SHIFT;
                end
            end
            SHIFT: begin
                tick_en = 1'b1;
                if (tick && last_edge) begin
                    nxt = TAIL;
                end
            end
            TAIL: begin
                tick_en = 1'b1;
                if (tick) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
        endcase
    end

    // Shift datapath: latch settings, toggle SCK, drive/sample bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr            <= '0;
            div_q         <= 8'd0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            ecnt          <= '0;
            sck           <= 1'b0;
            mosi          <= 1'b0;
            from_agent    <= '0;
            transfer_done <= 1'b0;
        end else begin
            transfer_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    sck  <= cpol;
                    mosi <= 1'b0;
                    if (accept) begin
                        sr     <= to_agent;
                        div_q  <= clk_div;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        ecnt   <= '0;
                        if (!cpha) begin
                            mosi <= to_agent[DATA_W-1];
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sck  <= ~sck;
                        ecnt <= ecnt + EW'(1);
                        if (sample_edge) begin
                            sr <= {sr[DATA_W-2:0], miso};
                        end else if (!last_edge) begin
                            mosi <= sr[DATA_W-1];
                        end
                    end
                end
                TAIL: begin
                    if (tick) begin
                        transfer_done <= 1'b1;
                        from_agent    <= sr;
                    end
                end
                DONE: begin
                    mosi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine with an SPI slave
// model that watches SCK edges and checks mode, timing and data.
`timescale 1ns/1ps
module tb_spi_shift_engine;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] clk_div;
    logic       cpol;
    logic       cpha;
    logic       transfer_req;
    logic       transfer_ready;
    logic       transfer_done;
    logic [7:0] to_agent;
    logic [7:0] from_agent;
    logic       sck;
    logic       mosi;
    logic       miso;

    always #5 clk = ~clk;

    spi_shift_engine #(.DATA_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_div        (clk_div),
        .cpol           (cpol),
        .cpha           (cpha),
        .transfer_req   (transfer_req),
        .transfer_ready (transfer_ready),
        .transfer_done  (transfer_done),
        .to_agent       (to_agent),
        .from_agent     (from_agent),
        .sck            (sck),
        .mosi           (mosi),
        .miso           (miso)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Per-transfer plan (written by tests) and observations (by monitor).
    logic [1:0] mode_b[32];
    int         div_b[32];
    logic [7:0] tx_b[32];
    logic [7:0] sl_b[32];
    logic [7:0] mo_cap[32];
    logic [7:0] rx_got[32];
    int lat[32], acc_neg[32], done_neg[32], nedges[32];
    int sp_err[32], ph_err[32], mo_err[32], first_dly[32];

    int ncyc = 0, acc_cnt = 0, done_cnt = 0;
    int cur = 0, ecnt = 0, last_neg = 0, k = 0;
    bit armed = 0, pend = 0, smp = 0;
    logic p_sck = 1'b0, p_mosi = 1'b0;

    // Slave/monitor: samples everything on the falling clk edge.
    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            armed = 0;
            pend  = 0;
        end else if (pend) begin
            pend  = 0;
            armed = 1;
            cur   = acc_cnt;
            acc_cnt++;
            acc_neg[cur]   = ncyc;
            last_neg       = ncyc;
            ecnt           = 0;
            p_sck          = sck;
            p_mosi         = mosi;
            mo_cap[cur]    = 8'h00;
            sp_err[cur]    = 0;
            ph_err[cur]    = 0;
            mo_err[cur]    = 0;
            first_dly[cur] = -1;
        end else begin
            if (armed) begin
                if (sck !== p_sck) begin
                    ecnt++;
                    if (ecnt == 1)
                        first_dly[cur] = ncyc - last_neg;
                    else if (ncyc - last_neg != div_b[cur] + 1)
                        sp_err[cur]++;
                    last_neg = ncyc;
                    smp = mode_b[cur][0] ? (ecnt % 2 == 0) : (ecnt % 2 == 1);
                    if (smp) begin
                        if (sck !== ~(mode_b[cur][1] ^ mode_b[cur][0]))
                            ph_err[cur]++;
                        if (mosi !== p_mosi) mo_err[cur]++;
                        mo_cap[cur] = {mo_cap[cur][6:0], mosi};
                    end else if (ecnt < 16) begin
                        k = mode_b[cur][0] ? 7 - (ecnt - 1) / 2 : 7 - ecnt / 2;
                        miso = sl_b[cur][k];
                    end
                end else if (mosi !== p_mosi) begin
                    mo_err[cur]++;
                end
                p_sck  = sck;
                p_mosi = mosi;
            end
            if (transfer_done === 1'b1) begin
                done_cnt++;
                if (armed) begin
                    done_neg[cur] = ncyc;
                    lat[cur]      = ncyc - acc_neg[cur];
                    rx_got[cur]   = from_agent;
                    nedges[cur]   = ecnt;
                    armed = 0;
                end
            end
            if (transfer_req && transfer_ready) begin
                pend = 1;
                if (!mode_b[acc_cnt][0]) miso = sl_b[acc_cnt][7];
            end
        end
    end

    task automatic xfer(input logic [1:0] mode, input int div,
                        input logic [7:0] tx, input logic [7:0] sl,
                        input int ndiv, input logic ncpol,
                        output int idx, output bit tmo);
        int d0;
        tmo = 0;
        idx = acc_cnt;
        d0  = done_cnt;
        mode_b[idx] = mode;
        div_b[idx]  = div;
        tx_b[idx]   = tx;
        sl_b[idx]   = sl;
        @(posedge clk); #1;
        clk_div  = div[7:0];
        cpol     = mode[1];
        cpha     = mode[0];
        to_agent = tx;
        transfer_req = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == idx; i++) @(posedge clk);
        #1;
        transfer_req = 1'b0;
        clk_div  = ndiv[7:0];
        cpol     = ncpol;
        to_agent = 8'($urandom);
        if (acc_cnt == idx) tmo = 1;
        for (int i = 0; i < 17 * (div + 1) + 40 && done_cnt == d0; i++)
            @(posedge clk);
        if (done_cnt == d0) tmo = 1;
    endtask

    task automatic test_one(input string nm, input logic [1:0] mode,
                            input int div, input logic [7:0] tx,
                            input logic [7:0] sl);
        int idx;
        bit tmo;
        xfer(mode, div, tx, sl, div, mode[1], idx, tmo);
        n_chk++;
        if (tmo) begin
            n_fail++;
            $display("FAIL %s timeout: no accept/done within budget", nm);
            return;
        end
        n_chk++;
        if (lat[idx] != 17 * (div + 1)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat[idx], 17 * (div + 1));
        end
        n_chk++;
        if (rx_got[idx] !== sl) begin
            n_fail++;
            $display("FAIL %s from_agent: got %h want %h", nm, rx_got[idx], sl);
        end
        n_chk++;
        if (mo_cap[idx] !== tx) begin
            n_fail++;
            $display("FAIL %s mosi bits: got %h want %h", nm, mo_cap[idx], tx);
        end
        n_chk++;
        if (nedges[idx] != 16) begin
            n_fail++;
            $display("FAIL %s sck edges: got %0d want 16", nm, nedges[idx]);
        end
        n_chk++;
        if (first_dly[idx] != div + 1) begin
            n_fail++;
            $display("FAIL %s first edge: got %0d want %0d", nm, first_dly[idx], div + 1);
        end
        n_chk++;
        if (sp_err[idx] + ph_err[idx] + mo_err[idx] != 0) begin
            n_fail++;
            $display("FAIL %s edge errors: spacing %0d phase %0d mosi %0d want 0 0 0",
                     nm, sp_err[idx], ph_err[idx], mo_err[idx]);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (from_agent !== sl || sck !== mode[1]) begin
            n_fail++;
            $display("FAIL %s idle: from_agent %h sck %b want %h %b",
                     nm, from_agent, sck, sl, mode[1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (sck !== 1'b0 || mosi !== 1'b0) begin
            n_fail++;
            $display("FAIL reset pins: sck %b mosi %b want 0 0", sck, mosi);
        end
        n_chk++;
        if (from_agent !== 8'h00 || transfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outs: from_agent %h done %b want 00 0", from_agent, transfer_done);
        end
        n_chk++;
        if (transfer_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready: got %b want 1", transfer_ready);
        end
    endtask

    task automatic test_modes();
        test_one("mode0_div0", MODE0, 0, 8'hA5, 8'h3C);
        test_one("mode3_div3", MODE3, 3, 8'h81, 8'hE7);
        test_one("mode1_div1", MODE1, 1, 8'h5A, 8'hC3);
        test_one("mode2_div1", MODE2, 1, 8'h5A, 8'hC3);
    endtask

    task automatic test_back_to_back();
        int idx, d0, div, per;
        div = $urandom_range(0, 2);
        per = 17 * (div + 1);
        idx = acc_cnt;
        d0  = done_cnt;
        for (int j = 0; j < 2; j++) begin
            mode_b[idx + j] = MODE0;
            div_b[idx + j]  = div;
        end
        tx_b[idx] = 8'h12;
        tx_b[idx + 1] = 8'h34;
        sl_b[idx] = 8'($urandom);
        sl_b[idx + 1] = 8'($urandom);
        @(posedge clk); #1;
        clk_div = div[7:0];
        cpol = 1'b0;
        cpha = 1'b0;
        to_agent = 8'h12;
        transfer_req = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == idx; i++) @(posedge clk);
        #1 to_agent = 8'h34;
        for (int i = 0; i < per + 20 && acc_cnt < idx + 2; i++) @(posedge clk);
        #1 transfer_req = 1'b0;
        for (int i = 0; i < per + 20 && done_cnt < d0 + 2; i++) @(posedge clk);
        n_chk++;
        if (done_cnt != d0 + 2) begin
            n_fail++;
            $display("FAIL b2b done count: got %0d want %0d", done_cnt - d0, 2);
            return;
        end
        for (int j = 0; j < 2; j++) begin
            n_chk++;
            if (rx_got[idx + j] !== sl_b[idx + j] || mo_cap[idx + j] !== tx_b[idx + j]) begin
                n_fail++;
                $display("FAIL b2b data%0d: rx %h mosi %h want %h %h", j,
                         rx_got[idx + j], mo_cap[idx + j], sl_b[idx + j], tx_b[idx + j]);
            end
        end
        n_chk++;
        if (done_neg[idx + 1] - done_neg[idx] != per + 2) begin
            n_fail++;
            $display("FAIL b2b done gap: got %0d want %0d",
                     done_neg[idx + 1] - done_neg[idx], per + 2);
        end
        n_chk++;
        if (acc_neg[idx + 1] - done_neg[idx] != 2) begin
            n_fail++;
            $display("FAIL b2b idle gap: got %0d want 2", acc_neg[idx + 1] - done_neg[idx]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_param_change();
        int idx;
        bit tmo;
        xfer(MODE0, 2, 8'hC6, 8'h9D, 255, 1'b1, idx, tmo);
        n_chk++;
        if (tmo || lat[idx] != 51 || sp_err[idx] != 0 || ph_err[idx] != 0) begin
            n_fail++;
            $display("FAIL chg current: tmo %0d lat %0d sp %0d ph %0d want 0 51 0 0",
                     tmo, lat[idx], sp_err[idx], ph_err[idx]);
        end
        n_chk++;
        if (rx_got[idx] !== 8'h9D || mo_cap[idx] !== 8'hC6) begin
            n_fail++;
            $display("FAIL chg data: rx %h mosi %h want 9d c6", rx_got[idx], mo_cap[idx]);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (sck !== 1'b1) begin
            n_fail++;
            $display("FAIL chg idle cpol: sck %b want 1", sck);
        end
        xfer(MODE2, 255, 8'h3E, 8'h71, 255, 1'b1, idx, tmo);
        n_chk++;
        if (tmo || lat[idx] != 4352 || first_dly[idx] != 256) begin
            n_fail++;
            $display("FAIL chg next: tmo %0d lat %0d first %0d want 0 4352 256",
                     tmo, lat[idx], first_dly[idx]);
        end
        n_chk++;
        if (rx_got[idx] !== 8'h71 || mo_cap[idx] !== 8'h3E || ph_err[idx] != 0) begin
            n_fail++;
            $display("FAIL chg next data: rx %h mosi %h ph %0d want 71 3e 0",
                     rx_got[idx], mo_cap[idx], ph_err[idx]);
        end
    endtask

    task automatic test_reset_mid();
        int idx, d0;
        idx = acc_cnt;
        mode_b[idx] = MODE2;
        div_b[idx]  = 1;
        tx_b[idx]   = 8'hF0;
        sl_b[idx]   = 8'h0F;
        @(posedge clk); #1;
        clk_div = 8'd1;
        cpol = 1'b1;
        cpha = 1'b0;
        to_agent = 8'hF0;
        transfer_req = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == idx; i++) @(posedge clk);
        #1 transfer_req = 1'b0;
        for (int i = 0; i < 60 && armed && ecnt < 7; i++) @(negedge clk);
        n_chk++;
        if (!(armed && ecnt == 7)) begin
            n_fail++;
            $display("FAIL rst_mid reach edge7: armed %0d edges %0d want 1 7", armed, ecnt);
        end
        d0 = done_cnt;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (sck !== 1'b0 || mosi !== 1'b0 || from_agent !== 8'h00 || transfer_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid state: sck %b mosi %b rx %h rdy %b want 0 0 00 1",
                     sck, mosi, from_agent, transfer_ready);
        end
        repeat (60) @(posedge clk);
        n_chk++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL rst_mid done: got %0d pulses want 0", done_cnt - d0);
        end
        test_one("after_reset", MODE1, 1, 8'h69, 8'hB4);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            test_one("random", 2'($urandom), $urandom_range(0, 4),
                     8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        reset = 1'b1;
        clk_div = 8'd0;
        cpol = 1'b0;
        cpha = 1'b0;
        transfer_req = 1'b0;
        to_agent = 8'h00;
        miso = 1'b0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_param_change();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
